time_set_entry: RTL and testbench

Button-driven time-entry controller that produces the four BCD digits and the `set` strobe consumed by the alarm-clock timekeeping block. It preloads the clock's current hour and minute, lets the user step through and edit the four digits (HH:MM), and enforces valid ranges while editing. On commit it issues a clean single-cycle `set` edge. It sits between the board push-buttons and the clock core, and also drives the digit-select and blink information used by the display scanner.

---
 rtl/time_set_entry.sv | 203 ++++++++++++++++++++
 tb/tb_time_set_entry.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_entry.sv
// Push-button HH:MM entry controller: preloads the running time, edits four BCD
// digits with range wrap, and publishes them with a registered one-cycle set strobe.

module tse_debounce #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_prev_q;
    logic [CW-1:0] cnt_q;

    // Level only flips after DEB_CYCLES back-to-back disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pulse_o = level_q & ~level_prev_q;
endmodule

module time_set_entry #(
    parameter int DEB_CYCLES     = 20000,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_cancel,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    output logic [3:0] hour1,
    output logic [3:0] hour0,
    output logic [3:0] minute1,
    output logic [3:0] minute0,
    output logic       set,
    output logic       editing,
    output logic [1:0] digit_sel
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_H1, S_H0, S_M1, S_M0, S_COMMIT, S_STROBE
    } state_t;

    logic [2:0] btn_raw, btn_pulse;
    logic       p_mode, p_up, p_cancel;

    assign btn_raw = {btn_cancel, btn_up, btn_mode};

    for (genvar i = 0; i < 3; i++) begin : g_deb
        tse_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn_raw[i]),
            .pulse_o(btn_pulse[i])
        );
    end

    assign p_mode   = btn_pulse[0];
    assign p_up     = btn_pulse[1];
    assign p_cancel = btn_pulse[2];

    state_t          state_q, state_d;
    logic [3:0][3:0] edit_q, edit_d;   // [3]=H1 [2]=H0 [1]=M1 [0]=M0
    logic [3:0][3:0] out_q, out_d;
    logic [TW-1:0]   to_q, to_d;
    logic            to_expired;
    logic            set_q, set_d;
    logic            editing_q, editing_d;
    logic [1:0]      sel_q, sel_d;

    // Out-of-range values collapse to 00 rather than showing nonsense digits.
    function automatic logic [7:0] to_bcd(input logic [5:0] v, input logic [5:0] vmax);
        logic [3:0] tens;
        logic [3:0] units;
        if      (v >= 6'd50) tens = 4'd5;
        else if (v >= 6'd40) tens = 4'd4;
        else if (v >= 6'd30) tens = 4'd3;
        else if (v >= 6'd20) tens = 4'd2;
        else if (v >= 6'd10) tens = 4'd1;
        else                 tens = 4'd0;
        units = 4'(v - {2'b00, tens} * 6'd10);
        if (v > vmax) return 8'h00;
        return {tens, units};
    endfunction

    assign to_expired = (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        out_d   = out_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (p_mode && !p_cancel) begin
                    edit_d  = {to_bcd(cur_hour, 6'd23), to_bcd(cur_minute, 6'd59)};
                    to_d    = '0;
                    state_d = S_H1;
                end
            end
            S_H1, S_H0, S_M1, S_M0: begin
                if (p_cancel || to_expired) begin
                    state_d = S_IDLE;
                end else if (p_mode) begin
                    to_d = '0;
                    case (state_q)
                        S_H1:    state_d = S_H0;
                        S_H0:    state_d = S_M1;
                        S_M1:    state_d = S_M0;
                        default: begin
                            state_d = S_COMMIT;
                            out_d   = edit_q;   // digits settle a cycle ahead of set
                        end
                    endcase
                end else if (p_up) begin
                    to_d = '0;
                    case (state_q)
                        S_H1: begin
                            edit_d[3] = (edit_q[3] >= 4'd2) ? 4'd0 : edit_q[3] + 4'd1;
                            if (edit_d[3] == 4'd2 && edit_q[2] > 4'd3) edit_d[2] = 4'd3;
                        end
                        S_H0: edit_d[2] = (edit_q[2] >= ((edit_q[3] == 4'd2) ? 4'd3 : 4'd9))
                                          ? 4'd0 : edit_q[2] + 4'd1;
                        S_M1: edit_d[1] = (edit_q[1] >= 4'd5) ? 4'd0 : edit_q[1] + 4'd1;
                        default: edit_d[0] = (edit_q[0] >= 4'd9) ? 4'd0 : edit_q[0] + 4'd1;
                    endcase
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_COMMIT: state_d = S_STROBE;
            default:  state_d = S_IDLE;
        endcase

        editing_d = 1'b1;
        case (state_d)
            S_H1:    sel_d = 2'd3;
            S_H0:    sel_d = 2'd2;
            S_M1:    sel_d = 2'd1;
            S_M0:    sel_d = 2'd0;
            default: begin
                sel_d     = 2'd0;
                editing_d = 1'b0;
            end
        endcase
        set_d = (state_d == S_STROBE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            edit_q    <= '0;
            out_q     <= '0;
            to_q      <= '0;
            set_q     <= 1'b0;
            editing_q <= 1'b0;
            sel_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            edit_q    <= edit_d;
            out_q     <= out_d;
            to_q      <= to_d;
            set_q     <= set_d;
            editing_q <= editing_d;
            sel_q     <= sel_d;
        end
    end

    assign hour1     = out_q[3];
    assign hour0     = out_q[2];
    assign minute1   = out_q[1];
    assign minute0   = out_q[0];
    assign set       = set_q;
    assign editing   = editing_q;
    assign digit_sel = sel_q;
endmodule

// File: tb/tb_time_set_entry.sv
// Directed + randomized sessions for time_set_entry, checked against a digit-level
// model of the editing rules.

module tb_time_set_entry;
    localparam int DEB = 8;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_cancel = 1'b0;
    logic [5:0] cur_hour = '0, cur_minute = '0;
    logic [3:0] hour1, hour0, minute1, minute0;
    logic       set, editing;
    logic [1:0] digit_sel;

    time_set_entry #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_cancel(btn_cancel),
        .cur_hour(cur_hour), .cur_minute(cur_minute),
        .hour1(hour1), .hour0(hour0), .minute1(minute1), .minute0(minute0),
        .set(set), .editing(editing), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0;
    int          cyc = 0, press_cyc = 0;
    int          set_cnt = 0, rise_cyc = -100;
    logic        set_prev = 1'b0;
    logic [15:0] dig_prev = '0, dig_at_rise = '0;
    logic [15:0] out_m = '0;
    int          e[4];
    wire  [15:0] digits = {hour1, hour0, minute1, minute0};

    always @(posedge clk) cyc <= cyc + 1;

    // Tracks set width/count and the digit value one cycle before its rising edge.
    always @(negedge clk) begin
        if (set === 1'b1) set_cnt <= set_cnt + 1;
        if (set === 1'b1 && set_prev !== 1'b1) begin
            rise_cyc    <= cyc;
            dig_at_rise <= dig_prev;
        end
        set_prev <= set;
        dig_prev <= digits;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic m, input logic u, input logic c);
        @(negedge clk);
        press_cyc  = cyc;
        btn_mode   = m;
        btn_up     = u;
        btn_cancel = c;
        repeat (12) @(negedge clk);
        btn_mode   = 1'b0;
        btn_up     = 1'b0;
        btn_cancel = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic model_up(input int k);
        case (k)
            3: begin
                e[3] = (e[3] + 1) % 3;
                if (e[3] == 2 && e[2] > 3) e[2] = 3;
            end
            2:       e[2] = (e[2] + 1) % ((e[3] == 2) ? 4 : 10);
            1:       e[1] = (e[1] + 1) % 6;
            default: e[0] = (e[0] + 1) % 10;
        endcase
    endtask

    task automatic edit(input int h, input int m, input int n3, input int n2,
                        input int n1, input int n0, input bit commit);
        logic [15:0] exp;
        int hh, mm, n, s0, lat;
        hh = (h > 23) ? 0 : h;
        mm = (m > 59) ? 0 : m;
        e[3] = hh / 10; e[2] = hh % 10; e[1] = mm / 10; e[0] = mm % 10;
        cur_hour   = 6'(h);
        cur_minute = 6'(m);
        press(1'b1, 1'b0, 1'b0);
        check("enter_editing", 32'(editing), 32'd1);
        check("enter_sel", 32'(digit_sel), 32'd3);
        for (int k = 3; k >= 0; k--) begin
            n = (k == 3) ? n3 : (k == 2) ? n2 : (k == 1) ? n1 : n0;
            repeat (n) begin
                press(1'b0, 1'b1, 1'b0);
                model_up(k);
            end
            if (k > 0) begin
                press(1'b1, 1'b0, 1'b0);
                check("step_sel", 32'(digit_sel), 32'(k - 1));
            end
        end
        exp = {e[3][3:0], e[2][3:0], e[1][3:0], e[0][3:0]};
        s0 = set_cnt;
        if (commit) begin
            press(1'b1, 1'b0, 1'b0);
            lat = rise_cyc - press_cyc;
            check("set_once", 32'(set_cnt - s0), 32'd1);
            check("set_latency", 32'(lat >= 11 && lat <= 13), 32'd1);
            check("digits_before_set", 32'(dig_at_rise), 32'(exp));
            check("commit_digits", 32'(digits), 32'(exp));
            out_m = exp;
        end else begin
            press(1'b0, 1'b0, 1'b1);
            check("cancel_no_set", 32'(set_cnt - s0), 32'd0);
            check("cancel_digits", 32'(digits), 32'(out_m));
        end
        check("done_editing", 32'(editing), 32'd0);
        check("done_sel", 32'(digit_sel), 32'd0);
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_set", 32'(set), 32'd0);
        check("rst_editing", 32'(editing), 32'd0);
        check("rst_sel", 32'(digit_sel), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        edit(13, 45, 1, 0, 1, 1, 1'b1);
        check("full_entry", 32'(digits), 32'h2356);
        edit(23, 59, 0, 1, 1, 1, 1'b1);
        check("wrap_h0_m1_m0", 32'(digits), 32'h2000);
        edit(22, 0, 1, 0, 0, 0, 1'b1);
        check("wrap_h1", 32'(digits), 32'h0200);
        edit(23, 59, 0, 0, 0, 0, 1'b1);
        check("preload_max", 32'(digits), 32'h2359);
        edit(30, 7, 0, 0, 0, 0, 1'b1);
        check("preload_bad_hour", 32'(digits), 32'h0007);
        edit(8, 30, 0, 0, 0, 0, 1'b1);
        edit(12, 34, 1, 1, 1, 1, 1'b0);
        check("cancel_keeps", 32'(digits), 32'h0830);

        // Idle session must time out without touching the outputs.
        s0 = set_cnt;
        cur_hour = 6'd11; cur_minute = 6'd11;
        press(1'b1, 1'b0, 1'b0);
        check("tmo_enter", 32'(editing), 32'd1);
        repeat (30) @(negedge clk);
        check("tmo_before", 32'(editing), 32'd1);
        repeat (15) @(negedge clk);
        check("tmo_after", 32'(editing), 32'd0);
        check("tmo_sel", 32'(digit_sel), 32'd0);
        check("tmo_no_set", 32'(set_cnt - s0), 32'd0);
        check("tmo_digits", 32'(digits), 32'h0830);

        // Short glitch is filtered; a long hold yields a single pulse.
        @(negedge clk); btn_mode = 1'b1;
        repeat (5) @(negedge clk); btn_mode = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch", 32'(editing), 32'd0);
        @(negedge clk); btn_mode = 1'b1;
        repeat (20) @(negedge clk); btn_mode = 1'b0;
        repeat (15) @(negedge clk);
        check("long_press_edit", 32'(editing), 32'd1);
        check("long_press_sel", 32'(digit_sel), 32'd3);
        press(1'b0, 1'b0, 1'b1);
        check("long_press_cancel", 32'(editing), 32'd0);

        // mode+up together: mode wins, H1 untouched.
        cur_hour = 6'd14; cur_minute = 6'd27;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        check("simul_sel", 32'(digit_sel), 32'd2);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("simul_digits", 32'(digits), 32'h1427);
        out_m = 16'h1427;

        repeat (8) begin
            edit(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of EDIT_H0.
        edit(9, 15, 0, 0, 0, 0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("pre_rst_sel", 32'(digit_sel), 32'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_digits", 32'(digits), 32'd0);
        check("arst_set", 32'(set), 32'd0);
        check("arst_editing", 32'(editing), 32'd0);
        check("arst_sel", 32'(digit_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
